// File: rtl/w21_mac_c5.sv
// Column-5 dot-product MAC: streams N_WEIGHTS x*w products through a registered multiplier.
// Optional W21_MAC_RELU_EN clamps a negative final sum to zero.
module w21_mac_c5 #(
  parameter int N_WEIGHTS = 300,
  parameter int XW        = 16,
  parameter int ACC_W     = 46
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [XW-1:0]    x_data,
  input  logic [20:0]      weight,
  output logic [8:0]       adrs_clm,
  output logic             busy,
  output logic             done,
  output logic [ACC_W-1:0] result
);

  localparam int PW = XW + 21;
  localparam logic [8:0] LAST = 9'(N_WEIGHTS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t state_q, state_d;
  logic [8:0] adrs_q, adrs_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic signed [PW-1:0] prod_q, prod_d;
  logic pv_q, pv_d;
  logic [ACC_W-1:0] res_q, res_d;
  logic done_q, done_d;

  logic signed [PW-1:0] prod_full;
  logic signed [ACC_W-1:0] prod_ext;
  logic signed [ACC_W-1:0] sum;
  logic [ACC_W-1:0] res_load;

  assign prod_full = $signed(x_data) * $signed(weight);
  assign prod_ext = ACC_W'(prod_q);
  assign sum = acc_q + (pv_q ? prod_ext : '0);

`ifdef W21_MAC_RELU_EN
  assign res_load = sum[ACC_W-1] ? '0 : sum;
`else
  assign res_load = sum;
`endif

  always_comb begin
    state_d = state_q;
    adrs_d  = adrs_q;
    acc_d   = sum;
    prod_d  = prod_q;
    pv_d    = pv_q;
    res_d   = res_q;
    done_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          adrs_d  = '0;
          acc_d   = '0;
          pv_d    = 1'b0;
        end
      end
      S_RUN: begin
        prod_d = prod_full;
        pv_d   = 1'b1;
        if (adrs_q == LAST) begin
          state_d = S_DRAIN;
        end else begin
          adrs_d = adrs_q + 9'd1;
        end
      end
      S_DRAIN: begin
        pv_d    = 1'b0;
        res_d   = res_load;
        done_d  = 1'b1;
        state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
        adrs_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      adrs_q  <= '0;
      acc_q   <= '0;
      prod_q  <= '0;
      pv_q    <= 1'b0;
      res_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      adrs_q  <= adrs_d;
      acc_q   <= acc_d;
      prod_q  <= prod_d;
      pv_q    <= pv_d;
      res_q   <= res_d;
      done_q  <= done_d;
    end
  end

  assign adrs_clm = adrs_q;
  assign busy     = (state_q != S_IDLE);
  assign done     = done_q;
  assign result   = res_q;

endmodule

// File: tb/tb_w21_mac_c5.sv
// Bench for w21_mac_c5: directed and random jobs against an arithmetic dot-product model.
// Honours W21_MAC_RELU_EN when computing expected results.
module tb_w21_mac_c5;

  localparam int N  = 300;
  localparam int XW = 16;
  localparam int AW = 46;

  logic clk, rst, start;
  logic [XW-1:0] x_data;
  logic [20:0] weight;
  logic [8:0] adrs_clm;
  logic busy, done;
  logic [AW-1:0] result;

  logic [XW-1:0] xmem [512];
  logic [20:0]   wmem [512];
  logic [AW-1:0] prev_res;
  int checks = 0;
  int errors = 0;

  w21_mac_c5 #(.N_WEIGHTS(N), .XW(XW), .ACC_W(AW)) dut (
    .clk(clk), .rst(rst), .start(start),
    .x_data(x_data), .weight(weight),
    .adrs_clm(adrs_clm), .busy(busy),
    .done(done), .result(result)
  );

  assign x_data = xmem[adrs_clm];
  assign weight = wmem[adrs_clm];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic longint model();
    longint s = 0;
    for (int i = 0; i < N; i++)
      s += longint'($signed(xmem[i])) * longint'($signed(wmem[i]));
`ifdef W21_MAC_RELU_EN
    if (s < 0) s = 0;
`endif
    return s;
  endfunction

  task automatic set_x(input int mode, input int addr, input int val);
    for (int i = 0; i < 512; i++) begin
      case (mode)
        0: xmem[i] = '0;
        1: xmem[i] = (i == addr) ? XW'(val) : '0;
        2: xmem[i] = XW'(val);
        default: xmem[i] = XW'($urandom);
      endcase
    end
  endtask

  task automatic run_job(input int restart_at, input bit start_in_done,
                         input int rst_at);
    longint ex;
    logic [AW-1:0] e;
    bit seq_ok, early;
    int max_a, want;
    ex = model();
    e = ex[AW-1:0];
    seq_ok = 1'b1;
    early = 1'b0;
    max_a = 0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("e0_busy", 64'(busy), 64'd1);
    chk("e0_adrs", 64'(adrs_clm), 64'd0);
    for (int k = 1; k <= N + 2; k++) begin
      @(posedge clk); #1;
      if (k <= N + 1) begin
        want = (k < N) ? k : N - 1;
        if (int'(adrs_clm) != want) seq_ok = 1'b0;
        if (int'(adrs_clm) > max_a) max_a = int'(adrs_clm);
      end
      if (k <= N && done) early = 1'b1;
      if (k == N / 2) chk("result_held", 64'(result), 64'(prev_res));
      if (rst_at >= 0 && k == rst_at) begin
        #2 rst = 1'b1;
        #1;
        chk("rst_adrs", 64'(adrs_clm), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_result", 64'(result), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int j = 0; j < N + 5; j++) begin
          @(posedge clk); #1;
          if (done || busy) early = 1'b1;
        end
        chk("rst_no_done", 64'(early), 64'd0);
        prev_res = '0;
        return;
      end
      if (restart_at >= 0 && k == restart_at) start = 1'b1;
      if (restart_at >= 0 && k == restart_at + 1) start = 1'b0;
      if (k == N + 1) begin
        chk("done_pulse", 64'(done), 64'd1);
        chk("result", 64'(result), 64'(e));
        chk("drain_busy", 64'(busy), 64'd1);
        if (start_in_done) start = 1'b1;
      end
      if (k == N + 2) begin
        start = 1'b0;
        chk("done_clear", 64'(done), 64'd0);
        chk("idle_busy", 64'(busy), 64'd0);
        chk("idle_adrs", 64'(adrs_clm), 64'd0);
        chk("adrs_seq", 64'(seq_ok), 64'd1);
        chk("adrs_max", 64'(max_a), 64'(N - 1));
        chk("no_early_done", 64'(early), 64'd0);
      end
    end
    if (start_in_done) begin
      @(posedge clk); #1;
      chk("no_requeue", 64'(busy), 64'd0);
    end
    prev_res = e;
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    prev_res = '0;
    for (int i = 0; i < 512; i++) begin
      wmem[i] = 21'($urandom);
      xmem[i] = '0;
    end
    wmem[0] = 21'(79);
    wmem[7] = 21'(-277);
    #1;
    chk("reset_adrs", 64'(adrs_clm), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_result", 64'(result), 64'd0);
    #11 rst = 1'b0;
    @(negedge clk);

    set_x(0, 0, 0);   run_job(-1, 1'b0, -1);
    set_x(1, 0, 1);   run_job(-1, 1'b0, -1);
    set_x(1, 7, 1);   run_job(-1, 1'b0, -1);
    set_x(1, 7, -1);  run_job(-1, 1'b0, -1);
    set_x(2, 0, 1);   run_job(-1, 1'b0, -1);
    set_x(2, 0, -1);  run_job(-1, 1'b0, -1);
    set_x(3, 0, 0);   run_job(-1, 1'b0, -1);
    set_x(3, 0, 0);   run_job(100, 1'b1, -1);
    set_x(3, 0, 0);   run_job(-1, 1'b0, -1);
    set_x(3, 0, 0);   run_job(-1, 1'b0, 150);
    set_x(3, 0, 0);   run_job(-1, 1'b0, -1);
    set_x(3, 0, 0);   run_job(-1, 1'b0, -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/w21_mac_c5.md
W21_MAC_C5 -- requirements
Module: w21_mac_c5

Interface
REQ-001 SHALL have parameter N_WEIGHTS, default 300, number of weights (dot-product length), legal range 1..512.
REQ-002 SHALL have parameter XW, default 16, signed feature sample width.
REQ-003 SHALL have parameter ACC_W, default 46, signed accumulator/result width (XW+21+9).
REQ-004 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1  reset; asynchronous, active-high.
REQ-006 SHALL have port start  input  1  request one dot product; sampled only in IDLE.
REQ-007 SHALL have port x_data  input  XW  signed feature sample for current adrs_clm; combinational source.
REQ-008 SHALL have port weight  input  21  signed weight from column-5 weight ROM for current adrs_clm; combinational source.
REQ-009 SHALL have port adrs_clm  output  9  registered address shared by the weight ROM and the feature source.
REQ-010 SHALL have port busy  output  1  high in RUN, DRAIN and DONE.
REQ-011 SHALL have port done  output  1  one-cycle pulse; result valid.
REQ-012 SHALL have port result  output  ACC_W  signed dot product; held until the next done.

Function
REQ-013 SHALL implement the states IDLE, RUN, DRAIN and DONE.
REQ-014 SHALL transition IDLE->RUN on the edge sampling start=1 (edge E0), setting adrs_clm=0, clearing the accumulator and clearing the product-valid flag.
REQ-015 SHALL, in RUN, register the full 37-bit signed product x_data*weight with a valid flag on each edge, then increment adrs_clm; no wrap.
REQ-016 SHALL hold adrs_clm at N_WEIGHTS-1 and enter DRAIN on edge E(N_WEIGHTS) when it captures the product for adrs_clm=N_WEIGHTS-1; adrs_clm never exceeds N_WEIGHTS-1.
REQ-017 SHALL sign-extend each valid registered product to ACC_W and add it to the accumulator one edge after capture.
REQ-018 SHALL add the last product on edge E(N_WEIGHTS+1). On that same edge the block SHALL load result, set done=1 and move DRAIN->DONE.
REQ-019 SHALL clear done on the following edge, return DONE->IDLE and return adrs_clm to 0.
REQ-020 SHALL ignore start in RUN, DRAIN and DONE: no restart and no queuing.
REQ-021 SHALL accept start on the first IDLE cycle after DONE. Back-to-back jobs are separated by exactly one IDLE cycle.
REQ-022 SHALL never overflow the accumulator for N_WEIGHTS<=512 at ACC_W=46. If ACC_W is reduced, arithmetic SHALL wrap modulo 2^ACC_W.
REQ-023 SHALL keep result at its last value, unchanged, while a new job runs.

Reset
REQ-024 SHALL, on rst=1 and without waiting for clk, force state=IDLE, adrs_clm=0, busy=0, done=0, result=0, accumulator=0, product register=0 and product-valid=0.
REQ-025 SHALL abandon any job in progress when rst asserts mid-operation, with no done pulse; the first start after release SHALL produce a correct, fresh result.

Configuration
REQ-026 SHALL support macro W21_MAC_RELU_EN. When defined, a negative final sum SHALL load result=0 and non-negative sums SHALL load unchanged. Timing SHALL be identical.
REQ-027 SHALL, with W21_MAC_RELU_EN undefined, load result with the raw signed sum.

Verification
REQ-028 SHALL cover: x_data=0 for all addresses, start at E0 -> done high only in cycle after E301, result=0, busy low after E302.
REQ-029 SHALL cover: x_data=1 only at adrs 0 (weight 79) -> result=79.
REQ-030 SHALL cover: x_data=1 only at adrs 7 (weight -277) -> result=-277 without macro, result=0 with W21_MAC_RELU_EN. With x_data=-1 at adrs 7 -> result=277 in both builds.
REQ-031 SHALL cover: x_data=1 at all addresses -> result equals the sum of all 300 column-5 weights from the golden model, and adrs_clm sequence 0..299 is observed with no value >299.
REQ-032 SHALL cover: start re-pulsed at adrs 100 and during DONE -> ignored, single done. Then a start one cycle after done -> second job completes correctly.
REQ-033 SHALL cover: rst asserted asynchronously at adrs 150 -> all outputs 0 immediately, no done. A start after release -> correct result, with latency unchanged.
